// File: rtl/switch_event_encoder_if.sv
// Event handshake between the switch encoder (master) and its consumer (slave).
interface switch_event_encoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_idx;
  logic       evt_level;

  modport master (output evt_valid, output evt_idx, output evt_level, input evt_ready);
  modport slave  (input evt_valid, input evt_idx, input evt_level, output evt_ready);
endinterface

// File: rtl/switch_event_encoder.sv
// Debounces three raw staircase switches, keeps lamp = XOR of the settled levels,
// and reports each settled toggle as an (index, level) event over valid/ready.
module switch_event_encoder #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             s_raw,
  switch_event_encoder_if.master evt,
  output logic [2:0]             sw_state,
  output logic                   lamp,
  output logic                   overflow
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state;
  logic [2:0]       sync1, sync2;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       pending;
  logic [2:0]       fire;
  logic [2:0]       next_sw;
  logic [2:0]       pick;
  logic [1:0]       pick_idx;
  logic [2:0]       take;

  // A bit settles once it has disagreed for DEB_CYCLES consecutive synced cycles.
  always_comb begin
    fire = '0;
    for (int i = 0; i < 3; i++) begin
      fire[i] = (sync2[i] != sw_state[i]) && (cnt[i] == CNT_W'(DEB_CYCLES - 1));
    end
  end

  assign next_sw = sw_state ^ fire;

  // Lowest pending switch wins: S1 before S2 before S3.
  always_comb begin
    pick     = 3'b000;
    pick_idx = 2'd0;
    if (pending[0]) begin
      pick     = 3'b001;
      pick_idx = 2'd1;
    end else if (pending[1]) begin
      pick     = 3'b010;
      pick_idx = 2'd2;
    end else if (pending[2]) begin
      pick     = 3'b100;
      pick_idx = 2'd3;
    end
  end

  assign take = (state == IDLE) ? pick : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      sw_state      <= '0;
      lamp          <= 1'b0;
      overflow      <= 1'b0;
      pending       <= '0;
      state         <= IDLE;
      evt.evt_valid <= 1'b0;
      evt.evt_idx   <= 2'd0;
      evt.evt_level <= 1'b0;
    end else begin
      // stage: two-flop synchroniser
      sync1 <= s_raw;
      sync2 <= sync1;

      // stage: debounce and settled state
      for (int i = 0; i < 3; i++) begin
        if ((sync2[i] == sw_state[i]) || fire[i]) cnt[i] <= '0;
        else                                      cnt[i] <= cnt[i] + 1'b1;
      end
      sw_state <= next_sw;
      lamp     <= ^next_sw;
      if (|(fire & pending)) overflow <= 1'b1;
      // A fresh toggle outranks the clear from the event being loaded this edge.
      pending  <= (pending & ~take) | fire;

      // stage: event presentation
      case (state)
        IDLE: begin
          if (|pending) begin
            state         <= PRESENT;
            evt.evt_valid <= 1'b1;
            evt.evt_idx   <= pick_idx;
            evt.evt_level <= |(sw_state & pick);
          end
        end
        PRESENT: begin
          if (evt.evt_ready) begin
            state         <= IDLE;
            evt.evt_valid <= 1'b0;
            evt.evt_idx   <= 2'd0;
            evt.evt_level <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_event_encoder.sv
// Directed bench for switch_event_encoder with a cycle monitor cross-checking the event stream.
module tb_switch_event_encoder;

  logic       clk;
  logic       rst;
  logic [2:0] s_raw;
  logic [2:0] sw_state;
  logic       lamp;
  logic       overflow;

  switch_event_encoder_if bus ();

  switch_event_encoder #(.DEB_CYCLES(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_raw    (s_raw),
    .evt      (bus),
    .sw_state (sw_state),
    .lamp     (lamp),
    .overflow (overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_evt(input string tag, input int idx, input int lvl, input int max_cyc);
    bit got = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      cyc(1);
      if (bus.evt_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(got), 1);
    if (got) begin
      chk({tag, "_idx"}, 32'(bus.evt_idx), idx);
      chk({tag, "_lvl"}, 32'(bus.evt_level), lvl);
    end
  endtask

  function automatic int lowest(input logic [2:0] p);
    if (p[0]) return 0;
    if (p[1]) return 1;
    return 2;
  endfunction

  // Output-level model: pending toggles follow observed settled-state changes.
  logic [2:0] m_pend, pv_sw, chg, clr;
  logic       m_ovf, pv_valid, pv_ready, pv_lvl;
  logic [1:0] pv_idx;

  always @(negedge clk) begin
    if (rst) begin
      m_pend = '0; m_ovf = 1'b0; pv_sw = '0;
      pv_valid = 1'b0; pv_ready = 1'b0; pv_idx = '0; pv_lvl = 1'b0;
    end else begin
      chk("mon_lamp", 32'(lamp), 32'(^sw_state));
      chg = sw_state ^ pv_sw;
      clr = '0;
      if (!pv_valid) begin
        chk("mon_load_valid", 32'(bus.evt_valid), 32'(m_pend != 3'b000));
        if (m_pend != 3'b000) begin
          chk("mon_load_idx", 32'(bus.evt_idx), lowest(m_pend) + 1);
          chk("mon_load_lvl", 32'(bus.evt_level), 32'(pv_sw[lowest(m_pend)]));
          clr[lowest(m_pend)] = 1'b1;
        end
      end else if (pv_ready) begin
        chk("mon_accept_valid", 32'(bus.evt_valid), 0);
        chk("mon_accept_idx", 32'(bus.evt_idx), 0);
      end else begin
        chk("mon_hold_valid", 32'(bus.evt_valid), 1);
        chk("mon_hold_idx", 32'(bus.evt_idx), 32'(pv_idx));
        chk("mon_hold_lvl", 32'(bus.evt_level), 32'(pv_lvl));
      end
      if ((chg & m_pend) != 3'b000) m_ovf = 1'b1;
      chk("mon_overflow", 32'(overflow), 32'(m_ovf));
      m_pend   = (m_pend & ~clr) | chg;
      pv_sw    = sw_state;
      pv_valid = bus.evt_valid;
      pv_ready = bus.evt_ready;
      pv_idx   = bus.evt_idx;
      pv_lvl   = bus.evt_level;
    end
  end

  initial begin
    int hold;
    rst = 1'b1;
    s_raw = 3'b000;
    bus.evt_ready = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(bus.evt_valid), 0);
    chk("rst_idx", 32'(bus.evt_idx), 0);
    chk("rst_lvl", 32'(bus.evt_level), 0);
    chk("rst_sw", 32'(sw_state), 0);
    chk("rst_lamp", 32'(lamp), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    cyc(3);

    // Single S1 toggle with exact latency.
    s_raw = 3'b001;
    cyc(5);
    chk("t2_sw_early", 32'(sw_state), 0);
    cyc(1);
    chk("t2_sw", 32'(sw_state), 1);
    chk("t2_lamp", 32'(lamp), 1);
    chk("t2_valid_early", 32'(bus.evt_valid), 0);
    cyc(1);
    chk("t2_valid", 32'(bus.evt_valid), 1);
    chk("t2_idx", 32'(bus.evt_idx), 1);
    chk("t2_lvl", 32'(bus.evt_level), 1);
    cyc(1);
    chk("t2_valid_drop", 32'(bus.evt_valid), 0);
    chk("t2_idx_drop", 32'(bus.evt_idx), 0);

    // Short S2 glitches are rejected, a 6-cycle pulse is two events.
    for (int w = 1; w <= 3; w++) begin
      s_raw = 3'b011;
      cyc(w);
      s_raw = 3'b001;
      cyc(10);
      chk("t3_glitch_sw", 32'(sw_state), 1);
      chk("t3_glitch_valid", 32'(bus.evt_valid), 0);
    end
    s_raw = 3'b011;
    cyc(6);
    s_raw = 3'b001;
    wait_evt("t3_rise", 2, 1, 12);
    wait_evt("t3_fall", 2, 0, 12);

    // Simultaneous toggles emerge in priority order on alternate cycles.
    s_raw = 3'b000;
    wait_evt("t4_clr", 1, 0, 12);
    cyc(2);
    chk("t4_lamp_pre", 32'(lamp), 0);
    s_raw = 3'b111;
    wait_evt("t4_e1", 1, 1, 12);
    cyc(1);
    chk("t4_gap1", 32'(bus.evt_valid), 0);
    cyc(1);
    chk("t4_e2_valid", 32'(bus.evt_valid), 1);
    chk("t4_e2_idx", 32'(bus.evt_idx), 2);
    chk("t4_e2_lvl", 32'(bus.evt_level), 1);
    cyc(1);
    chk("t4_gap2", 32'(bus.evt_valid), 0);
    cyc(1);
    chk("t4_e3_valid", 32'(bus.evt_valid), 1);
    chk("t4_e3_idx", 32'(bus.evt_idx), 3);
    chk("t4_e3_lvl", 32'(bus.evt_level), 1);
    chk("t4_lamp_on", 32'(lamp), 1);
    cyc(2);
    s_raw = 3'b011;
    wait_evt("t4_s3off", 3, 0, 12);
    chk("t4_lamp_off", 32'(lamp), 0);
    cyc(2);

    // Back-pressure: held payload, overflow on a second toggle, current level reported.
    bus.evt_ready = 1'b0;
    s_raw = 3'b010;
    wait_evt("t5_first", 1, 0, 12);
    s_raw = 3'b011;
    cyc(8);
    chk("t5_ovf_pre", 32'(overflow), 0);
    chk("t5_hold_valid", 32'(bus.evt_valid), 1);
    chk("t5_hold_idx", 32'(bus.evt_idx), 1);
    chk("t5_hold_lvl", 32'(bus.evt_level), 0);
    s_raw = 3'b010;
    cyc(8);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_hold_idx2", 32'(bus.evt_idx), 1);
    chk("t5_hold_lvl2", 32'(bus.evt_level), 0);
    s_raw = 3'b011;
    cyc(8);
    chk("t5_sw", 32'(sw_state), 3);
    bus.evt_ready = 1'b1;
    cyc(1);
    chk("t5_accept", 32'(bus.evt_valid), 0);
    wait_evt("t5_second", 1, 1, 4);
    chk("t5_ovf_sticky", 32'(overflow), 1);
    cyc(1);

    // Asynchronous reset while an event is being presented.
    bus.evt_ready = 1'b0;
    s_raw = 3'b001;
    wait_evt("t1_pres", 2, 0, 12);
    cyc(2);
    chk("t1_pres_hold", 32'(bus.evt_valid), 1);
    rst = 1'b1;
    #1;
    chk("t1_async_valid", 32'(bus.evt_valid), 0);
    chk("t1_async_idx", 32'(bus.evt_idx), 0);
    chk("t1_async_ovf", 32'(overflow), 0);
    chk("t1_async_sw", 32'(sw_state), 0);
    s_raw = 3'b000;
    cyc(2);
    rst = 1'b0;
    bus.evt_ready = 1'b1;
    cyc(15);
    chk("t1_post_valid", 32'(bus.evt_valid), 0);
    chk("t1_post_sw", 32'(sw_state), 0);

    // Random switches and back-pressure; the monitor checks every cycle.
    hold = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold == 0) begin
        s_raw = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 14);
      end
      hold--;
      bus.evt_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    bus.evt_ready = 1'b1;
    cyc(25);
    chk("t6_settled_sw", 32'(sw_state), 32'(s_raw));
    chk("t6_settled_lamp", 32'(lamp), 32'(^s_raw));
    chk("t6_drained", 32'(bus.evt_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
